// File: rtl/full_stage_link.sv
// Buffered interconnect between consecutive network stages: per link, a forward and a
// backward FIFO, with a frame-length check applied to beats leaving the forward FIFO.
module full_stage_link #(
  parameter int WIDTH     = 32,
  parameter int NUM_LINKS = 1,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        err_clr,
  input  logic [NUM_LINKS*WIDTH-1:0]                  fwd_in,
  input  logic [NUM_LINKS-1:0]                        fwd_in_fst,
  input  logic [NUM_LINKS-1:0]                        fwd_in_vld,
  output logic [NUM_LINKS-1:0]                        fwd_in_rdy,
  output logic [NUM_LINKS*WIDTH-1:0]                  fwd_out,
  output logic [NUM_LINKS-1:0]                        fwd_out_fst,
  output logic [NUM_LINKS-1:0]                        fwd_out_vld,
  input  logic [NUM_LINKS-1:0]                        fwd_out_rdy,
  input  logic [NUM_LINKS*WIDTH-1:0]                  bwd_in,
  input  logic [NUM_LINKS-1:0]                        bwd_in_fst,
  input  logic [NUM_LINKS-1:0]                        bwd_in_vld,
  output logic [NUM_LINKS-1:0]                        bwd_in_rdy,
  output logic [NUM_LINKS*WIDTH-1:0]                  bwd_out,
  output logic [NUM_LINKS-1:0]                        bwd_out_fst,
  output logic [NUM_LINKS-1:0]                        bwd_out_vld,
  input  logic [NUM_LINKS-1:0]                        bwd_out_rdy,
  output logic [NUM_LINKS*($clog2(DEPTH)+1)-1:0]      fwd_level,
  output logic [NUM_LINKS-1:0]                        frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 2);

  for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
    // d = 0 is the forward FIFO, d = 1 the backward FIFO; both are identical.
    for (genvar d = 0; d < 2; d++) begin : g_dir
      logic [WIDTH:0]   mem_q [DEPTH];
      logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
      logic [AW:0]      level_q, level_d;
      logic [WIDTH-1:0] inData;
      logic             inFst, inVld, inRdy, outVld, outRdy, push, pop;

      if (d == 0) begin : g_fwd
        assign inData    = fwd_in[k*WIDTH +: WIDTH];
        assign inFst     = fwd_in_fst[k];
        assign inVld     = fwd_in_vld[k];
        assign outRdy    = fwd_out_rdy[k];
        assign fwd_in_rdy[k]  = inRdy;
        assign fwd_out_vld[k] = outVld;
        assign {fwd_out_fst[k], fwd_out[k*WIDTH +: WIDTH]} = mem_q[rdPtr_q];
        assign fwd_level[k*(AW+1) +: AW+1] = level_q;
      end else begin : g_bwd
        assign inData    = bwd_in[k*WIDTH +: WIDTH];
        assign inFst     = bwd_in_fst[k];
        assign inVld     = bwd_in_vld[k];
        assign outRdy    = bwd_out_rdy[k];
        assign bwd_in_rdy[k]  = inRdy;
        assign bwd_out_vld[k] = outVld;
        assign {bwd_out_fst[k], bwd_out[k*WIDTH +: WIDTH]} = mem_q[rdPtr_q];
      end

      // Handshakes depend only on the registered level, so there is no in->out path.
      assign inRdy  = (level_q != (AW+1)'(DEPTH));
      assign outVld = (level_q != '0);
      assign push   = inVld & inRdy;
      assign pop    = outVld & outRdy;

      always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop ? rdPtr_q + 1'b1 : rdPtr_q;
        level_d = level_q;
        if (push && !pop) begin
          level_d = level_q + 1'b1;
        end else if (pop && !push) begin
          level_d = level_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          wrPtr_q <= '0;
          rdPtr_q <= '0;
          level_q <= '0;
        end else begin
          wrPtr_q <= wrPtr_d;
          rdPtr_q <= rdPtr_d;
          level_q <= level_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wrPtr_q] <= {inFst, inData};
        end
      end
    end

    if (FRAME_LEN != 0) begin : g_chk
      localparam logic [CW-1:0] FL = CW'(FRAME_LEN);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          seen_q, seen_d, err_q, err_d, popFwd, badBeat;

      assign popFwd = fwd_out_vld[k] & fwd_out_rdy[k];

      // A frame is judged only when the next fst arrives, so a trailing short frame is silent.
      always_comb begin
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        badBeat = 1'b0;
        if (popFwd) begin
          if (fwd_out_fst[k]) begin
            badBeat = seen_q && (cnt_q != FL);
            cnt_d   = CW'(1);
            seen_d  = 1'b1;
          end else if (!seen_q) begin
            badBeat = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        err_d = err_clr ? 1'b0 : (err_q | badBeat);
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_q  <= '0;
          seen_q <= 1'b0;
          err_q  <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          seen_q <= seen_d;
          err_q  <= err_d;
        end
      end

      assign frame_err[k] = err_q;
    end else begin : g_nochk
      assign frame_err[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_full_stage_link.sv
// Self-checking bench for full_stage_link: a negedge scoreboard/model watches all four
// FIFOs and the frame check, while scenario tasks add targeted checks of their own.
module tb_full_stage_link;

  localparam int WIDTH     = 32;
  localparam int NL        = 2;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 8;
  localparam int AW        = 2;
  localparam int CMAX      = (1 << $clog2(FRAME_LEN + 2)) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 err_clr = 1'b0;
  logic [NL*WIDTH-1:0]  fwd_in = '0, bwd_in = '0;
  logic [NL-1:0]        fwd_in_fst = '0, fwd_in_vld = '0, fwd_out_rdy = '0;
  logic [NL-1:0]        bwd_in_fst = '0, bwd_in_vld = '0, bwd_out_rdy = '0;
  logic [NL*WIDTH-1:0]  fwd_out, bwd_out;
  logic [NL-1:0]        fwd_in_rdy, fwd_out_fst, fwd_out_vld;
  logic [NL-1:0]        bwd_in_rdy, bwd_out_fst, bwd_out_vld;
  logic [NL*(AW+1)-1:0] fwd_level;
  logic [NL-1:0]        frame_err;

  int checks = 0;
  int failures = 0;

  full_stage_link #(.WIDTH(WIDTH), .NUM_LINKS(NL), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .reset(reset), .err_clr(err_clr),
    .fwd_in(fwd_in), .fwd_in_fst(fwd_in_fst), .fwd_in_vld(fwd_in_vld), .fwd_in_rdy(fwd_in_rdy),
    .fwd_out(fwd_out), .fwd_out_fst(fwd_out_fst), .fwd_out_vld(fwd_out_vld), .fwd_out_rdy(fwd_out_rdy),
    .bwd_in(bwd_in), .bwd_in_fst(bwd_in_fst), .bwd_in_vld(bwd_in_vld), .bwd_in_rdy(bwd_in_rdy),
    .bwd_out(bwd_out), .bwd_out_fst(bwd_out_fst), .bwd_out_vld(bwd_out_vld), .bwd_out_rdy(bwd_out_rdy),
    .fwd_level(fwd_level), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard queues: 0..NL-1 forward links, NL..2*NL-1 backward links.
  logic [WIDTH:0] sbq [2*NL][$];
  int             lvl [2*NL];
  int             cntM [NL];
  bit             seenM [NL];
  logic [NL-1:0]  errM = '0;

  logic           mIv, mIr, mOv, mOr, mPush, mPop, mErr;
  logic [WIDTH:0] mIn, mOut, mExp;
  int             mK;

  // Inputs change just after posedge, so at negedge they show what the next edge will do.
  always @(negedge clk) begin
    if (!reset) begin
      for (int f = 0; f < 2*NL; f++) begin
        sbq[f].delete();
        lvl[f] = 0;
      end
      for (int k = 0; k < NL; k++) begin
        cntM[k]  = 0;
        seenM[k] = 1'b0;
      end
      errM = '0;
    end else begin
      for (int f = 0; f < 2*NL; f++) begin
        mK = f % NL;
        if (f < NL) begin
          mIv = fwd_in_vld[mK]; mIr = fwd_in_rdy[mK]; mOv = fwd_out_vld[mK]; mOr = fwd_out_rdy[mK];
          mIn  = {fwd_in_fst[mK], fwd_in[mK*WIDTH +: WIDTH]};
          mOut = {fwd_out_fst[mK], fwd_out[mK*WIDTH +: WIDTH]};
        end else begin
          mIv = bwd_in_vld[mK]; mIr = bwd_in_rdy[mK]; mOv = bwd_out_vld[mK]; mOr = bwd_out_rdy[mK];
          mIn  = {bwd_in_fst[mK], bwd_in[mK*WIDTH +: WIDTH]};
          mOut = {bwd_out_fst[mK], bwd_out[mK*WIDTH +: WIDTH]};
        end
        checks++;
        if (mOv !== (lvl[f] != 0)) begin
          failures++;
          $display("[TB] FAIL outVld fifo%0d t=%0t: got %b want %b", f, $time, mOv, lvl[f] != 0);
        end
        checks++;
        if (mIr !== (lvl[f] != DEPTH)) begin
          failures++;
          $display("[TB] FAIL inRdy fifo%0d t=%0t: got %b want %b", f, $time, mIr, lvl[f] != DEPTH);
        end
        if (f < NL) begin
          checks++;
          if (fwd_level[mK*(AW+1) +: AW+1] !== (AW+1)'(lvl[f])) begin
            failures++;
            $display("[TB] FAIL level link%0d t=%0t: got %0d want %0d", mK, $time,
                     fwd_level[mK*(AW+1) +: AW+1], lvl[f]);
          end
          checks++;
          if (frame_err[mK] !== errM[mK]) begin
            failures++;
            $display("[TB] FAIL frameErr link%0d t=%0t: got %b want %b", mK, $time, frame_err[mK], errM[mK]);
          end
        end
        mPush = mIv && (lvl[f] != DEPTH);
        mPop  = mOr && (lvl[f] != 0);
        mExp  = '0;
        if (mPop) begin
          checks++;
          if (sbq[f].size() == 0) begin
            failures++;
            $display("[TB] FAIL sbUnderflow fifo%0d t=%0t: got a pop want none", f, $time);
          end else begin
            mExp = sbq[f].pop_front();
            if (mOut !== mExp) begin
              failures++;
              $display("[TB] FAIL sbData fifo%0d t=%0t: got %h want %h", f, $time, mOut, mExp);
            end
          end
        end
        if (f < NL) begin
          mErr = 1'b0;
          if (mPop) begin
            if (mExp[WIDTH]) begin
              mErr = seenM[mK] && (cntM[mK] != FRAME_LEN);
              cntM[mK]  = 1;
              seenM[mK] = 1'b1;
            end else if (!seenM[mK]) begin
              mErr = 1'b1;
            end else if (cntM[mK] != CMAX) begin
              cntM[mK]++;
            end
          end
          errM[mK] = err_clr ? 1'b0 : (errM[mK] | mErr);
        end
        if (mPush) sbq[f].push_back(mIn);
        lvl[f] = lvl[f] + int'(mPush) - int'(mPop);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fwd_in_vld = '0; bwd_in_vld = '0; fwd_out_rdy = '0; bwd_out_rdy = '0;
    fwd_in_fst = '0; bwd_in_fst = '0; fwd_in = '0; bwd_in = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({fwd_out_vld, bwd_out_vld} !== '0) begin
      failures++;
      $display("[TB] FAIL resetOutVld: got %b want 0", {fwd_out_vld, bwd_out_vld});
    end
    checks++;
    if ({fwd_in_rdy, bwd_in_rdy} !== '1) begin
      failures++;
      $display("[TB] FAIL resetInRdy: got %b want 1111", {fwd_in_rdy, bwd_in_rdy});
    end
    checks++;
    if (fwd_level !== '0 || frame_err !== '0) begin
      failures++;
      $display("[TB] FAIL resetLevelErr: got level %h err %b want 0", fwd_level, frame_err);
    end
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fwd_in_vld[0] = 1'b1;
      fwd_in_fst[0] = (i == 0);
      fwd_in[0 +: WIDTH] = 32'h3F80_0000 + 32'(i);
      @(negedge clk);
      checks++;
      if (fwd_level[0 +: AW+1] !== 3'(i)) begin
        failures++;
        $display("[TB] FAIL fillLevel beat%0d: got %0d want %0d", i, fwd_level[0 +: AW+1], i);
      end
      tick();
    end
    fwd_in_fst[0] = 1'b0;
    fwd_in[0 +: WIDTH] = 32'h3F80_0004;
    @(negedge clk);
    checks++;
    if (fwd_in_rdy[0] !== 1'b0 || fwd_level[0 +: AW+1] !== 3'd4) begin
      failures++;
      $display("[TB] FAIL fillFull: got rdy %b level %0d want rdy 0 level 4", fwd_in_rdy[0], fwd_level[0 +: AW+1]);
    end
    checks++;
    if (fwd_out[0 +: WIDTH] !== 32'h3F80_0000 || fwd_out_fst[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fillHead: got %h fst %b want 3f800000 fst 1", fwd_out[0 +: WIDTH], fwd_out_fst[0]);
    end
    tick();
  endtask

  task automatic test_full_flow();
    fwd_out_rdy[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (fwd_level[0 +: AW+1] !== 3'd4 || fwd_in_rdy[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flowC0: got level %0d rdy %b want 4 0", fwd_level[0 +: AW+1], fwd_in_rdy[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fwd_level[0 +: AW+1] !== 3'd3 || fwd_in_rdy[0] !== 1'b1 || fwd_out[0 +: WIDTH] !== 32'h3F80_0001) begin
      failures++;
      $display("[TB] FAIL flowC1: got level %0d rdy %b head %h want 3 1 3f800001",
               fwd_level[0 +: AW+1], fwd_in_rdy[0], fwd_out[0 +: WIDTH]);
    end
    tick();
    fwd_in[0 +: WIDTH] = 32'h3F80_0005;
    @(negedge clk);
    checks++;
    if (fwd_level[0 +: AW+1] !== 3'd3) begin
      failures++;
      $display("[TB] FAIL flowSteady: got level %0d want 3", fwd_level[0 +: AW+1]);
    end
    tick();
    fwd_in[0 +: WIDTH] = 32'h3F80_0006;
    fwd_out_rdy[0] = 1'b0;
    tick();
    fwd_in_vld[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_level[0 +: AW+1] !== 3'd4 || fwd_in_rdy[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flowRefill: got level %0d rdy %b want 4 0", fwd_level[0 +: AW+1], fwd_in_rdy[0]);
    end
    fwd_out_rdy[0] = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    checks++;
    if (fwd_out_vld[0] !== 1'b0 || sbq[0].size() != 0) begin
      failures++;
      $display("[TB] FAIL flowDrain: got vld %b pending %0d want 0 0", fwd_out_vld[0], sbq[0].size());
    end
    tick();
  endtask

  task automatic test_frame();
    do_reset();
    fwd_out_rdy[0] = 1'b1;
    for (int i = 0; i < 23; i++) begin
      fwd_in_vld[0] = 1'b1;
      fwd_in_fst[0] = (i == 0) || (i == 8) || (i == 16);
      fwd_in[0 +: WIDTH] = 32'h4000_0000 + 32'(i);
      tick();
    end
    fwd_in_vld[0] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (frame_err !== 2'b00) begin
      failures++;
      $display("[TB] FAIL frameGood: got %b want 00", frame_err);
    end
    fwd_in_vld[0] = 1'b1;
    fwd_in_fst[0] = 1'b1;
    fwd_in[0 +: WIDTH] = 32'h4000_0100;
    tick();
    fwd_in_vld[0] = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (frame_err !== 2'b01) begin
      failures++;
      $display("[TB] FAIL frameShort: got %b want 01", frame_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_err !== 2'b00) begin
      failures++;
      $display("[TB] FAIL frameClr: got %b want 00", frame_err);
    end
    tick();
  endtask

  task automatic test_no_fst();
    do_reset();
    fwd_out_rdy = 2'b11;
    fwd_in_vld = 2'b11;
    fwd_in_fst = 2'b10;
    fwd_in = {32'h5000_0001, 32'h5000_0000};
    tick();
    fwd_in_vld = 2'b00;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (frame_err !== 2'b01) begin
      failures++;
      $display("[TB] FAIL noFst: got %b want 01", frame_err);
    end
    fwd_in_vld = 2'b01;
    fwd_in_fst = 2'b00;
    tick();
    fwd_in_vld = 2'b00;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_err !== 2'b00) begin
      failures++;
      $display("[TB] FAIL clrWins: got %b want 00", frame_err);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      fwd_in_vld  = 2'($urandom_range(3));
      bwd_in_vld  = 2'($urandom_range(3));
      fwd_out_rdy = 2'($urandom_range(3));
      bwd_out_rdy = 2'($urandom_range(3));
      for (int k = 0; k < NL; k++) begin
        fwd_in_fst[k] = ($urandom_range(7) == 0);
        bwd_in_fst[k] = ($urandom_range(7) == 0);
        fwd_in[k*WIDTH +: WIDTH] = $urandom;
        bwd_in[k*WIDTH +: WIDTH] = $urandom;
      end
      err_clr = ($urandom_range(63) == 0);
      tick();
    end
    idle();
    fwd_out_rdy = '1;
    bwd_out_rdy = '1;
    repeat (8) tick();
    @(negedge clk);
    for (int f = 0; f < 2*NL; f++) begin
      checks++;
      if (sbq[f].size() != 0) begin
        failures++;
        $display("[TB] FAIL randDrain fifo%0d: got %0d pending want 0", f, sbq[f].size());
      end
    end
    checks++;
    if ({fwd_out_vld, bwd_out_vld} !== '0 || fwd_level !== '0) begin
      failures++;
      $display("[TB] FAIL randEmpty: got vld %b level %h want 0", {fwd_out_vld, bwd_out_vld}, fwd_level);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fwd_in_vld[0] = 1'b1;
      fwd_in_fst[0] = (i == 0);
      fwd_in[0 +: WIDTH] = 32'h6000_0000 + 32'(i);
      tick();
    end
    fwd_in_vld[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_level[0 +: AW+1] !== 3'd3) begin
      failures++;
      $display("[TB] FAIL midLevel: got %0d want 3", fwd_level[0 +: AW+1]);
    end
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fwd_out_vld[0] !== 1'b0 || fwd_level[0 +: AW+1] !== 3'd0 || fwd_in_rdy[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midReset: got vld %b level %0d rdy %b want 0 0 1",
               fwd_out_vld[0], fwd_level[0 +: AW+1], fwd_in_rdy[0]);
    end
    tick();
    fwd_in_vld[0] = 1'b1;
    fwd_in_fst[0] = 1'b1;
    fwd_in[0 +: WIDTH] = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if (fwd_out_vld[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL noBypass: got vld %b want 0", fwd_out_vld[0]);
    end
    tick();
    fwd_in_vld[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_out_vld[0] !== 1'b1 || fwd_out[0 +: WIDTH] !== 32'hCAFE_F00D || fwd_out_fst[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL postResetPush: got vld %b data %h fst %b want 1 cafef00d 1",
               fwd_out_vld[0], fwd_out[0 +: WIDTH], fwd_out_fst[0]);
    end
    fwd_out_rdy[0] = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_flow();
    test_frame();
    test_no_fst();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
